// File: rtl/adc_volt_conv_mc.sv
// Multi-channel ADC offset-binary code to signed millivolt converter: trim/clamp, centre/scale, sign/saturate.
// Optional window averaging stage enabled by defining ADC_AVG_EN.
module adc_volt_conv_mc #(
  parameter int NCH      = 2,
  parameter int ADC_W    = 12,
  parameter int OFS_W    = 8,
  parameter int SCALE    = 20000,
  parameter int SCALE_W  = 16,
  parameter int SHIFT    = 13,
  parameter int AVG_LOG2 = 2,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   ad_clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  input  logic [NCH*ADC_W-1:0]   i_ad_data,
  input  logic                   i_cfg_we,
  input  logic [CH_W-1:0]        i_cfg_ch,
  input  logic [OFS_W-1:0]       i_cfg_ofs,
  input  logic                   i_ovr_clr,
  output logic                   o_out_valid,
  output logic [NCH*16-1:0]      o_volt,
  output logic [NCH-1:0]         o_ovr
);

  localparam int CW = ADC_W + 2;
  localparam int PW = ADC_W + 1 + SCALE_W;
  localparam logic [ADC_W:0] MID = (ADC_W+1)'(1) << (ADC_W - 1);

  logic [OFS_W-1:0] r_ofs [NCH];
  logic [NCH-1:0]   w_cfg_sel;

  logic [CW-1:0]    w_s1_sum [NCH];
  logic [ADC_W-1:0] w_s1_c   [NCH];
  logic [NCH-1:0]   w_s1_ov;
  logic             r_s1_vld;
  logic [ADC_W-1:0] r_s1_c   [NCH];
  logic [NCH-1:0]   r_s1_ov;

  logic [ADC_W:0]   w_s2_d   [NCH];
  logic [ADC_W:0]   w_s2_mag [NCH];
  logic [NCH-1:0]   w_s2_neg;
  logic [PW-1:0]    w_s2_m   [NCH];
  logic             r_s2_vld;
  logic [PW-1:0]    r_s2_m   [NCH];
  logic [NCH-1:0]   r_s2_neg;
  logic [NCH-1:0]   r_s2_ov;

  logic [15:0]      w_s3_v   [NCH];

  // Decode which trim register a configuration write targets; out-of-range channels match nothing.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      if (i_cfg_we && (i_cfg_ch == CH_W'(k))) begin
        w_cfg_sel[k] = 1'b1;
      end else begin
        w_cfg_sel[k] = 1'b0;
      end
    end
  end

  // Per-channel offset trim registers.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) r_ofs[k] <= {OFS_W{1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_cfg_sel[k]) r_ofs[k] <= i_cfg_ofs;
      end
    end
  end

  // S1 combinational: add sign-extended trim and clamp into the code range.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_s1_sum[k] = {2'b00, i_ad_data[k*ADC_W +: ADC_W]}
                  + {{(CW-OFS_W){r_ofs[k][OFS_W-1]}}, r_ofs[k]};
      if (w_s1_sum[k][CW-1]) begin
        w_s1_c[k]  = {ADC_W{1'b0}};
        w_s1_ov[k] = 1'b1;
      end else if (w_s1_sum[k][ADC_W]) begin
        w_s1_c[k]  = {ADC_W{1'b1}};
        w_s1_ov[k] = 1'b1;
      end else begin
        w_s1_c[k]  = w_s1_sum[k][ADC_W-1:0];
        w_s1_ov[k] = 1'b0;
      end
    end
  end

  // S1 registers; the over-range tag travels with its sample so it surfaces alongside the result.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_ov  <= {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) r_s1_c[k] <= {ADC_W{1'b0}};
    end else begin
      r_s1_vld <= i_in_valid;
      r_s1_ov  <= i_in_valid ? w_s1_ov : {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) r_s1_c[k] <= w_s1_c[k];
    end
  end

  // S2 combinational: centre, take the magnitude, scale it so truncation is toward zero.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_s2_d[k]   = {1'b0, r_s1_c[k]} - MID;
      w_s2_neg[k] = w_s2_d[k][ADC_W];
      w_s2_mag[k] = w_s2_neg[k] ? (-w_s2_d[k]) : w_s2_d[k];
      w_s2_m[k]   = (PW'(w_s2_mag[k]) * PW'(SCALE)) >> SHIFT;
    end
  end

  // S2 registers.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_neg <= {NCH{1'b0}};
      r_s2_ov  <= {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) r_s2_m[k] <= {PW{1'b0}};
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_neg <= w_s2_neg;
      r_s2_ov  <= r_s1_ov;
      for (int k = 0; k < NCH; k++) r_s2_m[k] <= w_s2_m[k];
    end
  end

  // S3 combinational: restore the sign and saturate to the signed 16-bit range.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      if (r_s2_neg[k]) begin
        if (r_s2_m[k] > PW'(32768)) w_s3_v[k] = 16'h8000;
        else                        w_s3_v[k] = -r_s2_m[k][15:0];
      end else begin
        if (r_s2_m[k] > PW'(32767)) w_s3_v[k] = 16'h7FFF;
        else                        w_s3_v[k] = r_s2_m[k][15:0];
      end
    end
  end

`ifdef ADC_AVG_EN
  localparam int AW = 16 + AVG_LOG2;

  logic                r_s3_vld;
  logic [NCH-1:0]      r_s3_ov;
  logic signed [15:0]  r_s3_v   [NCH];
  logic signed [AW-1:0] r_acc   [NCH];
  logic signed [AW-1:0] w_s4_tot [NCH];
  logic [AVG_LOG2-1:0] r_cnt;

  // S3 registers feeding the averaging stage.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_vld <= 1'b0;
      r_s3_ov  <= {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) r_s3_v[k] <= 16'sd0;
    end else begin
      r_s3_vld <= r_s2_vld;
      r_s3_ov  <= r_s2_ov;
      for (int k = 0; k < NCH; k++) r_s3_v[k] <= w_s3_v[k];
    end
  end

  // Running window sum including the sample currently at S3.
  always_comb begin
    for (int k = 0; k < NCH; k++) w_s4_tot[k] = r_acc[k] + AW'(r_s3_v[k]);
  end

  // S4: accumulate a window of results, publish the mean on its last sample; a trim write restarts it.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= {AVG_LOG2{1'b0}};
      o_out_valid <= 1'b0;
      o_volt      <= {(NCH*16){1'b0}};
      o_ovr       <= {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) r_acc[k] <= {AW{1'b0}};
    end else begin
      o_out_valid <= 1'b0;
      o_ovr       <= (o_ovr & ~{NCH{i_ovr_clr}}) | r_s3_ov;
      if (|w_cfg_sel) begin
        r_cnt <= {AVG_LOG2{1'b0}};
        for (int k = 0; k < NCH; k++) r_acc[k] <= {AW{1'b0}};
      end else if (r_s3_vld) begin
        r_cnt <= r_cnt + {{(AVG_LOG2-1){1'b0}}, 1'b1};
        if (r_cnt == {AVG_LOG2{1'b1}}) begin
          o_out_valid <= 1'b1;
          for (int k = 0; k < NCH; k++) begin
            o_volt[k*16 +: 16] <= 16'(w_s4_tot[k] >>> AVG_LOG2);
            r_acc[k]           <= {AW{1'b0}};
          end
        end else begin
          for (int k = 0; k < NCH; k++) r_acc[k] <= w_s4_tot[k];
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end
`else
  // S3 output registers: volt holds between pulses, ovr set beats clear.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_volt      <= {(NCH*16){1'b0}};
      o_ovr       <= {NCH{1'b0}};
    end else begin
      o_out_valid <= r_s2_vld;
      o_ovr       <= (o_ovr & ~{NCH{i_ovr_clr}}) | r_s2_ov;
      if (r_s2_vld) begin
        for (int k = 0; k < NCH; k++) o_volt[k*16 +: 16] <= w_s3_v[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_volt_conv_mc.sv
// Bench for adc_volt_conv_mc in the default build: vector table plus trim, over-range and reset sequences.
module tb_adc_volt_conv_mc;

  logic        ad_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] ad_data = 24'd0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_ch = 1'b0;
  logic [7:0]  cfg_ofs = 8'd0;
  logic        ovr_clr = 1'b0;
  logic        out_valid;
  logic [31:0] volt;
  logic [1:0]  ovr;

  adc_volt_conv_mc dut (
    .ad_clk     (ad_clk),
    .rst_n      (rst_n),
    .i_in_valid (in_valid),
    .i_ad_data  (ad_data),
    .i_cfg_we   (cfg_we),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_ofs  (cfg_ofs),
    .i_ovr_clr  (ovr_clr),
    .o_out_valid(out_valid),
    .o_volt     (volt),
    .o_ovr      (ovr)
  );

  always #5 ad_clk = ~ad_clk;

  typedef struct {
    logic               vld;
    logic [11:0]        c0;
    logic [11:0]        c1;
    logic signed [15:0] e0;
    logic signed [15:0] e1;
  } vec_t;

  typedef struct {
    logic [31:0] volt;
    logic [1:0]  ovr;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [2:0] hist = 3'b000;
  bit         mon_en = 1'b0;
  vec_t       tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; a valid sample pushes its expected result to the scoreboard.
  task automatic drive(input logic vld, input logic [11:0] c0, input logic [11:0] c1,
                       input logic signed [15:0] e0, input logic signed [15:0] e1,
                       input logic [1:0] eovr);
    exp_t e;
    @(posedge ad_clk);
    #1;
    cfg_we   = 1'b0;
    ovr_clr  = 1'b0;
    in_valid = vld;
    ad_data  = {c1, c0};
    if (vld) begin
      e.volt = {e1, e0};
      e.ovr  = eovr;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'd0, 12'd0, 16'sd0, 16'sd0, 2'b00);
  endtask

  // Output monitor: out_valid must mirror in_valid three cycles earlier; each pulse pops one expectation.
  always @(negedge ad_clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        hist = 3'b000;
      end else begin
        check("out_valid_latency", {31'd0, out_valid}, {31'd0, hist[2]});
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got pulse, expected none at %0t", $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("volt", volt, e.volt);
            check("ovr_at_pulse", {30'd0, ovr}, {30'd0, e.ovr});
          end
        end
        hist = {hist[1:0], in_valid};
      end
    end
  end

  initial begin
    tbl[0] = '{1'b1, 12'd2048, 12'd2048,     16'sd0,     16'sd0};
    tbl[1] = '{1'b1, 12'd4095, 12'd0,     16'sd4997, -16'sd5000};
    tbl[2] = '{1'b1, 12'd0,    12'd4095, -16'sd5000,  16'sd4997};
    tbl[3] = '{1'b0, 12'd0,    12'd0,         16'sd0,     16'sd0};
    tbl[4] = '{1'b1, 12'd2049, 12'd2047,      16'sd2,    -16'sd2};
    tbl[5] = '{1'b1, 12'd1024, 12'd3072, -16'sd2500,  16'sd2500};
    tbl[6] = '{1'b1, 12'd1,    12'd2142, -16'sd4997,   16'sd229};

    mon_en = 1'b1;
    repeat (3) @(posedge ad_clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_volt", volt, 32'd0);
    check("reset_ovr", {30'd0, ovr}, 32'd0);
    rst_n = 1'b1;

    // Conversion table with a 1,1,1,0,1,1,1 valid pattern.
    for (int i = 0; i < 7; i++) drive(tbl[i].vld, tbl[i].c0, tbl[i].c1, tbl[i].e0, tbl[i].e1, 2'b00);
    idle(5);

    // Positive trim drives ch0 past full scale.
    idle(1);
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_ofs = 8'd80;
    drive(1'b1, 12'd4090, 12'd2048, 16'sd4997, 16'sd0, 2'b01);
    idle(5);
    check("ovr_sticky", {30'd0, ovr}, 32'd1);
    idle(1);
    ovr_clr = 1'b1;
    idle(1);
    check("ovr_clear", {30'd0, ovr}, 32'd0);

    // Clear coincides with a new over-range sample reaching the flag register: set wins.
    drive(1'b1, 12'd4095, 12'd2048, 16'sd4997, 16'sd0, 2'b01);
    idle(2);
    ovr_clr = 1'b1;
    idle(5);
    check("ovr_set_wins", {30'd0, ovr}, 32'd1);

    // Restore ch0 trim and clear flags, then write ch1 trim in the same cycle as a sample.
    idle(1);
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_ofs = 8'd0; ovr_clr = 1'b1;
    idle(1);
    check("ovr_clear2", {30'd0, ovr}, 32'd0);
    drive(1'b1, 12'd2048, 12'd2142, 16'sd0, 16'sd229, 2'b00);
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_ofs = 8'hA2;
    drive(1'b1, 12'd2048, 12'd2142, 16'sd0, 16'sd0, 2'b00);
    drive(1'b1, 12'd2048, 12'd50, 16'sd0, -16'sd5000, 2'b10);
    idle(5);

    // Reset mid-stream discards in-flight samples and clears trims.
    drive(1'b1, 12'd4095, 12'd4095, 16'sd4997, 16'sd4997, 2'b00);
    drive(1'b1, 12'd4095, 12'd4095, 16'sd4997, 16'sd4997, 2'b00);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_volt", volt, 32'd0);
    check("midrst_ovr", {30'd0, ovr}, 32'd0);
    sb.delete();
    repeat (2) @(posedge ad_clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 12'd2048, 12'd2142, 16'sd0, 16'sd229, 2'b00);
    idle(6);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
